// File: rtl/cpu_pkg.sv
// Shared types and constants for the SM83 core control path.
// Optional feature macro: SEQ_IRQ_EN (interrupt dispatch at opcode fetch).
package cpu_pkg;

  typedef logic [7:0] opcode_t;

  // Branch condition codes, encoded as they appear in opcode bits [4:3].
  typedef enum logic [1:0] {
    CC_NZ = 2'd0,
    CC_Z  = 2'd1,
    CC_NC = 2'd2,
    CC_C  = 2'd3
  } cc_t;

  // Sequencer control state: boot forces the very first M-cycle to be a fetch.
  typedef enum logic {
    SEQ_BOOT = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  // Unused opcode slot repurposed as the internal interrupt-dispatch instruction.
  localparam opcode_t OP_IRQ = 8'hD3;
  localparam opcode_t OP_RESET = 8'h00;
  localparam int T_PER_M_DEFAULT = 4;

  // Width of the T-cycle counter; never narrower than one bit.
  function automatic int t_width(input int t_per_m);
    return ($clog2(t_per_m) < 1) ? 1 : $clog2(t_per_m);
  endfunction

  // One-hot of the lowest set bit (lowest interrupt line wins).
  function automatic logic [4:0] lowest_one_hot(input logic [4:0] v);
    return v & (~v + 5'd1);
  endfunction

endpackage

// File: rtl/cc_eval.sv
// Branch condition evaluator: decides whether cc is satisfied by the Z/C flags.
module cc_eval
  import cpu_pkg::*;
(
  input  cc_t  cc_i,
  input  logic flag_z_i,
  input  logic flag_c_i,
  output logic cc_met_o
);

  // Pure decode of the four SM83 condition codes.
  always_comb begin
    cc_met_o = 1'b0;
    unique case (cc_i)
      CC_NZ: cc_met_o = ~flag_z_i;
      CC_Z:  cc_met_o = flag_z_i;
      CC_NC: cc_met_o = ~flag_c_i;
      CC_C:  cc_met_o = flag_c_i;
      default: cc_met_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: owns IR, step counter and T-cycle counter, overlaps the
// opcode fetch with each instruction's final M-cycle and stretches M-cycles on
// memory wait. Optional macro SEQ_IRQ_EN enables interrupt dispatch at fetch.
//
// Handshake: mem_ready is sampled only on the last T-cycle of an M-cycle; when
// low the M-cycle stretches (t_cycle holds, no m_end) and no architectural state
// changes. All IR/step/seq_err/irq_ack updates happen only on m_end.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int T_PER_M = T_PER_M_DEFAULT,
  localparam int TW = t_width(T_PER_M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    db_in,
  input  logic          mem_ready,
  input  logic          dec_done,
  input  logic          dec_is_cond,
  input  logic [2:0]    dec_next_cond,
  input  logic          flag_z,
  input  logic          flag_c,
  input  logic          ime,
  input  logic [4:0]    irq_req,
  output opcode_t       ir,
  output logic [2:0]    step,
  output logic [TW-1:0] t_cycle,
  output logic          m_end,
  output logic          fetch,
  output logic          seq_err,
  output logic [4:0]    irq_ack
);

  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);

  seq_state_t    state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  opcode_t       ir_q, ir_d;
  logic [2:0]    step_q, step_d;
  logic          err_q, err_d;
  logic [4:0]    ack_q, ack_d;

  logic t_last;
  logic step_ovf;
  logic cc_met;

`ifndef SEQ_IRQ_EN
  // Interrupt inputs have no function in this build.
  logic unused_irq;
  assign unused_irq = ^{ime, irq_req};
`endif

  cc_eval u_cc_eval (
    .cc_i     (cc_t'(ir_q[4:3])),
    .flag_z_i (flag_z),
    .flag_c_i (flag_c),
    .cc_met_o (cc_met)
  );

  assign t_last   = (t_q == T_LAST);
  assign m_end    = t_last & mem_ready;
  // Step 7 with no done is an overflow; it is forced into a fetch to recover.
  assign step_ovf = (step_q == 3'd7) & ~dec_done;
  assign fetch    = (state_q == SEQ_BOOT) | dec_done | (step_q == 3'd7);

  assign ir      = ir_q;
  assign step    = step_q;
  assign t_cycle = t_q;
  assign seq_err = err_q;
  assign irq_ack = ack_q;

  // State register with asynchronous reset; reset restarts via a boot fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_BOOT;
      t_q     <= '0;
      ir_q    <= OP_RESET;
      step_q  <= 3'd0;
      err_q   <= 1'b0;
      ack_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state: T-cycle advance/stall, then step/IR update on m_end.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    ir_d    = ir_q;
    step_d  = step_q;
    err_d   = err_q;
    ack_d   = 5'd0;

    if (t_last) begin
      if (mem_ready) t_d = '0;
    end else begin
      t_d = t_q + TW'(1);
    end

    if (m_end) begin
      state_d = SEQ_RUN;
      if (fetch) begin
        step_d = 3'd0;
        if (step_ovf) err_d = 1'b1;
`ifdef SEQ_IRQ_EN
        if (ime && (|irq_req)) begin
          ir_d  = OP_IRQ;
          ack_d = lowest_one_hot(irq_req);
        end else begin
          ir_d = db_in;
        end
`else
        ir_d = db_in;
`endif
      end else if (dec_is_cond && !cc_met) begin
        step_d = dec_next_cond;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer (T_PER_M = 4), with a cycle-level
// behavioural reference model. Honours SEQ_IRQ_EN if defined at compile time.
module tb_instr_sequencer;

  localparam int T = 4;

  logic       clk;
  logic       rst;
  logic [7:0] db_in;
  logic       mem_ready;
  logic       dec_done;
  logic       dec_is_cond;
  logic [2:0] dec_next_cond;
  logic       flag_z;
  logic       flag_c;
  logic       ime;
  logic [4:0] irq_req;
  logic [7:0] ir;
  logic [2:0] step;
  logic [1:0] t_cycle;
  logic       m_end;
  logic       fetch;
  logic       seq_err;
  logic [4:0] irq_ack;

  int n_compared = 0;
  int n_failed   = 0;

  // Reference model state
  int         m_t;
  int         m_step;
  logic [7:0] m_ir;
  bit         m_boot;
  bit         m_err;
  logic [4:0] m_ack;

  instr_sequencer #(.T_PER_M(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .db_in         (db_in),
    .mem_ready     (mem_ready),
    .dec_done      (dec_done),
    .dec_is_cond   (dec_is_cond),
    .dec_next_cond (dec_next_cond),
    .flag_z        (flag_z),
    .flag_c        (flag_c),
    .ime           (ime),
    .irq_req       (irq_req),
    .ir            (ir),
    .step          (step),
    .t_cycle       (t_cycle),
    .m_end         (m_end),
    .fetch         (fetch),
    .seq_err       (seq_err),
    .irq_ack       (irq_ack)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_step = 0; m_ir = 8'h00; m_boot = 1; m_err = 0; m_ack = 5'd0;
  endtask

  // Condition met when the selected flag equals opcode bit 3 (bit 4 selects C vs Z).
  function automatic bit model_cc_met(input logic [7:0] op, input logic z, input logic c);
    logic f;
    f = op[4] ? c : z;
    return (f == op[3]);
  endfunction

  // One clock: compare all outputs against the model, then advance the model.
  // Entered just after a negedge with inputs already driven.
  task automatic tick();
    bit         e_m_end, e_fetch;
    int         n_t, n_step;
    logic [7:0] n_ir;
    bit         n_boot, n_err;
    logic [4:0] n_ack;
    #1;
    e_m_end = (m_t == T - 1) && mem_ready;
    e_fetch = m_boot || dec_done || (m_step == 7);
    chk("m_end",   32'(m_end),   32'(e_m_end));
    chk("fetch",   32'(fetch),   32'(e_fetch));
    chk("t_cycle", 32'(t_cycle), 32'(m_t));
    chk("ir",      32'(ir),      32'(m_ir));
    chk("step",    32'(step),    32'(m_step));
    chk("seq_err", 32'(seq_err), 32'(m_err));
    chk("irq_ack", 32'(irq_ack), 32'(m_ack));

    n_t = m_t; n_step = m_step; n_ir = m_ir; n_boot = m_boot; n_err = m_err; n_ack = 5'd0;
    if (m_t < T - 1) n_t = m_t + 1;
    else if (mem_ready) n_t = 0;
    if (e_m_end) begin
      n_boot = 0;
      if (e_fetch) begin
        if (m_step == 7 && !dec_done) n_err = 1;
        n_step = 0;
        n_ir = db_in;
`ifdef SEQ_IRQ_EN
        if (ime && irq_req != 5'd0) begin
          n_ir = 8'hD3;
          for (int i = 4; i >= 0; i--)
            if (irq_req[i]) n_ack = 5'(1 << i);
        end
`endif
      end else if (dec_is_cond && !model_cc_met(m_ir, flag_z, flag_c)) begin
        n_step = int'(dec_next_cond);
      end else begin
        n_step = m_step + 1;
      end
    end
    @(posedge clk);
    m_t = n_t; m_step = n_step; m_ir = n_ir; m_boot = n_boot; m_err = n_err; m_ack = n_ack;
    @(negedge clk);
  endtask

  task automatic mcycle();
    repeat (T) tick();
  endtask

  // Asynchronous reset pulse raised between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_ir",      32'(ir),      32'h00);
    chk("rst_step",    32'(step),    32'h0);
    chk("rst_t",       32'(t_cycle), 32'h0);
    chk("rst_seq_err", 32'(seq_err), 32'h0);
    chk("rst_irq_ack", 32'(irq_ack), 32'h0);
    chk("rst_fetch",   32'(fetch),   32'h1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; db_in = 8'h3E; mem_ready = 1'b1; dec_done = 1'b0; dec_is_cond = 1'b0;
    dec_next_cond = 3'd0; flag_z = 1'b0; flag_c = 1'b0; ime = 1'b0; irq_req = 5'd0;
    model_reset();
    @(negedge clk);

    // 1: boot fetch loads 3E after four clocks
    do_reset();
    mcycle();
    chk("t1_ir",   32'(ir),   32'h3E);
    chk("t1_step", 32'(step), 32'h0);

    // 2: JR NZ with Z=1 takes the not-met path to step 3
    db_in = 8'h20; dec_done = 1'b1;
    mcycle();
    dec_done = 1'b0; db_in = 8'h3E;
    mcycle();
    chk("t2_ir",    32'(ir),   32'h20);
    chk("t2_step1", 32'(step), 32'h1);
    dec_is_cond = 1'b1; dec_next_cond = 3'd3; flag_z = 1'b1;
    mcycle();
    chk("t2_step_nc", 32'(step), 32'h3);

    // 3: JR NZ with Z=0 proceeds 1 -> 2
    dec_is_cond = 1'b0; dec_done = 1'b1; db_in = 8'h20;
    mcycle();
    dec_done = 1'b0;
    mcycle();
    dec_is_cond = 1'b1; flag_z = 1'b0;
    mcycle();
    chk("t3_step_met", 32'(step), 32'h2);

    // 4: memory wait at t=3 stretches the M-cycle
    dec_is_cond = 1'b0; db_in = 8'h3E;
    repeat (3) tick();
    mem_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t4_t_hold", 32'(t_cycle), 32'h3);
    end
    chk("t4_step_hold", 32'(step), 32'h2);
    mem_ready = 1'b1;
    tick();
    chk("t4_step_resume", 32'(step), 32'h3);

    // 5: runaway instruction overflows step 7 into a fetch with sticky error
    repeat (5) mcycle();
    chk("t5_step",    32'(step),    32'h0);
    chk("t5_seq_err", 32'(seq_err), 32'h1);
    repeat (2) mcycle();
    chk("t5_sticky",  32'(seq_err), 32'h1);

    // 6: interrupt request at a fetch boundary
    ime = 1'b1; irq_req = 5'b10100; dec_done = 1'b1; db_in = 8'h55;
    mcycle();
`ifdef SEQ_IRQ_EN
    chk("t6_ir",  32'(ir),      32'hD3);
    chk("t6_ack", 32'(irq_ack), 32'h04);
`else
    chk("t6_ir",  32'(ir),      32'h55);
    chk("t6_ack", 32'(irq_ack), 32'h00);
`endif
    ime = 1'b0; irq_req = 5'd0; dec_done = 1'b0;
    tick();
    chk("t6_ack_pulse", 32'(irq_ack), 32'h00);

    // Mid-instruction reset discards everything, including the sticky error
    tick();
    do_reset();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      db_in         = 8'($urandom_range(0, 255));
      mem_ready     = ($urandom_range(0, 4) != 0);
      dec_done      = ($urandom_range(0, 5) == 0);
      dec_is_cond   = ($urandom_range(0, 2) == 0);
      dec_next_cond = 3'($urandom_range(0, 7));
      flag_z        = 1'($urandom_range(0, 1));
      flag_c        = 1'($urandom_range(0, 1));
      ime           = 1'($urandom_range(0, 1));
      irq_req       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
